// File: rtl/umi_merger_pkg.sv
// Shared types and constants for the UMI response/request merger.
// Optional build macro UMI_MERGER_RESP_PRIO_EN is consumed by umi_merger_arb.
package umi_merger_pkg;

  localparam int UMI_EOM_BIT = 22;

  typedef enum logic [1:0] {
    IDLE_RR   = 2'd0,
    LOCK_RESP = 2'd1,
    LOCK_REQ  = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_RESP = 1'b0,
    SRC_REQ  = 1'b1
  } src_sel_t;

endpackage

// File: rtl/umi_merger_arb.sv
// Two-way arbiter with EOM message locking; round-robin when idle, or fixed
// response-over-request priority when UMI_MERGER_RESP_PRIO_EN is defined.
module umi_merger_arb
  import umi_merger_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic resp_valid,
  input  logic req_valid,
  input  logic accept,
  input  logic eom,
  output logic grant_resp,
  output logic grant_req
);

  arb_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE_RR;
    end else begin
      state_q <= state_d;
    end
  end

  // A non-EOM beat pins the arbiter to its source until that source's EOM.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (eom) begin
        state_d = IDLE_RR;
      end else begin
        state_d = grant_req ? LOCK_REQ : LOCK_RESP;
      end
    end
  end

`ifndef UMI_MERGER_RESP_PRIO_EN
  src_sel_t last_q, last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= SRC_REQ;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = grant_req ? SRC_REQ : SRC_RESP;
    end
  end
`endif

  always_comb begin
    grant_resp = 1'b0;
    grant_req  = 1'b0;
    if (!rst) begin
      case (state_q)
        LOCK_RESP: grant_resp = resp_valid;
        LOCK_REQ:  grant_req  = req_valid;
        default: begin
          if (resp_valid && req_valid) begin
`ifdef UMI_MERGER_RESP_PRIO_EN
            grant_resp = 1'b1;
`else
            grant_resp = (last_q == SRC_REQ);
            grant_req  = (last_q == SRC_RESP);
`endif
          end else begin
            grant_resp = resp_valid;
            grant_req  = req_valid;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/umi_merger.sv
// Merges a UMI response stream and a request stream onto one registered port.
// Define UMI_MERGER_RESP_PRIO_EN for fixed response priority instead of round-robin.
module umi_merger
  import umi_merger_pkg::*;
#(
  parameter int DW = 256,
  parameter int AW = 64,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          umi_resp_in_valid,
  output logic          umi_resp_in_ready,
  input  logic [CW-1:0] umi_resp_in_cmd,
  input  logic [AW-1:0] umi_resp_in_dstaddr,
  input  logic [AW-1:0] umi_resp_in_srcaddr,
  input  logic [DW-1:0] umi_resp_in_data,

  input  logic          umi_req_in_valid,
  output logic          umi_req_in_ready,
  input  logic [CW-1:0] umi_req_in_cmd,
  input  logic [AW-1:0] umi_req_in_dstaddr,
  input  logic [AW-1:0] umi_req_in_srcaddr,
  input  logic [DW-1:0] umi_req_in_data,

  output logic          umi_out_valid,
  input  logic          umi_out_ready,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data
);

  logic          grant_resp, grant_req, grant_valid;
  logic          out_free, load;
  logic [CW-1:0] sel_cmd;
  logic [AW-1:0] sel_dstaddr, sel_srcaddr;
  logic [DW-1:0] sel_data;

  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_cmd_q, out_cmd_d;
  logic [AW-1:0] out_dstaddr_q, out_dstaddr_d;
  logic [AW-1:0] out_srcaddr_q, out_srcaddr_d;
  logic [DW-1:0] out_data_q, out_data_d;

  umi_merger_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .resp_valid (umi_resp_in_valid),
    .req_valid  (umi_req_in_valid),
    .accept     (load),
    .eom        (sel_cmd[UMI_EOM_BIT]),
    .grant_resp (grant_resp),
    .grant_req  (grant_req)
  );

  assign grant_valid       = grant_resp | grant_req;
  assign out_free          = !out_valid_q | umi_out_ready;
  assign load              = out_free & grant_valid;
  assign umi_resp_in_ready = grant_resp & out_free;
  assign umi_req_in_ready  = grant_req & out_free;

  always_comb begin
    sel_cmd     = grant_req ? umi_req_in_cmd     : umi_resp_in_cmd;
    sel_dstaddr = grant_req ? umi_req_in_dstaddr : umi_resp_in_dstaddr;
    sel_srcaddr = grant_req ? umi_req_in_srcaddr : umi_resp_in_srcaddr;
    sel_data    = grant_req ? umi_req_in_data    : umi_resp_in_data;
  end

  // Payload only moves on load, so it stays stable while stalled.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_cmd_d     = out_cmd_q;
    out_dstaddr_d = out_dstaddr_q;
    out_srcaddr_d = out_srcaddr_q;
    out_data_d    = out_data_q;
    if (load) begin
      out_valid_d   = 1'b1;
      out_cmd_d     = sel_cmd;
      out_dstaddr_d = sel_dstaddr;
      out_srcaddr_d = sel_srcaddr;
      out_data_d    = sel_data;
    end else if (umi_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_cmd_q     <= '0;
      out_dstaddr_q <= '0;
      out_srcaddr_q <= '0;
      out_data_q    <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_cmd_q     <= out_cmd_d;
      out_dstaddr_q <= out_dstaddr_d;
      out_srcaddr_q <= out_srcaddr_d;
      out_data_q    <= out_data_d;
    end
  end

  assign umi_out_valid   = out_valid_q;
  assign umi_out_cmd     = out_cmd_q;
  assign umi_out_dstaddr = out_dstaddr_q;
  assign umi_out_srcaddr = out_srcaddr_q;
  assign umi_out_data    = out_data_q;

endmodule

// File: tb/tb_umi_merger.sv
// Scoreboard bench for umi_merger; define UMI_MERGER_RESP_PRIO_EN to check the
// fixed-priority build instead of round-robin.
module tb_umi_merger;

  typedef struct {
    logic [31:0]  cmd;
    logic [63:0]  dst;
    logic [63:0]  src;
    logic [255:0] data;
  } beat_t;

  logic         clk;
  logic         rst;
  logic         umi_resp_in_valid, umi_resp_in_ready;
  logic [31:0]  umi_resp_in_cmd;
  logic [63:0]  umi_resp_in_dstaddr, umi_resp_in_srcaddr;
  logic [255:0] umi_resp_in_data;
  logic         umi_req_in_valid, umi_req_in_ready;
  logic [31:0]  umi_req_in_cmd;
  logic [63:0]  umi_req_in_dstaddr, umi_req_in_srcaddr;
  logic [255:0] umi_req_in_data;
  logic         umi_out_valid, umi_out_ready;
  logic [31:0]  umi_out_cmd;
  logic [63:0]  umi_out_dstaddr, umi_out_srcaddr;
  logic [255:0] umi_out_data;

  int checkCount = 0;
  int passCount  = 0;

  beat_t respQ[$];
  beat_t reqQ[$];
  beat_t expQ[$];
  bit    presResp, presReq;
  int    lockSide;
  int    lastSide;

  umi_merger dut (
    .clk                 (clk),
    .rst                 (rst),
    .umi_resp_in_valid   (umi_resp_in_valid),
    .umi_resp_in_ready   (umi_resp_in_ready),
    .umi_resp_in_cmd     (umi_resp_in_cmd),
    .umi_resp_in_dstaddr (umi_resp_in_dstaddr),
    .umi_resp_in_srcaddr (umi_resp_in_srcaddr),
    .umi_resp_in_data    (umi_resp_in_data),
    .umi_req_in_valid    (umi_req_in_valid),
    .umi_req_in_ready    (umi_req_in_ready),
    .umi_req_in_cmd      (umi_req_in_cmd),
    .umi_req_in_dstaddr  (umi_req_in_dstaddr),
    .umi_req_in_srcaddr  (umi_req_in_srcaddr),
    .umi_req_in_data     (umi_req_in_data),
    .umi_out_valid       (umi_out_valid),
    .umi_out_ready       (umi_out_ready),
    .umi_out_cmd         (umi_out_cmd),
    .umi_out_dstaddr     (umi_out_dstaddr),
    .umi_out_srcaddr     (umi_out_srcaddr),
    .umi_out_data        (umi_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [415:0] packBeat(beat_t b);
    return {b.cmd, b.dst, b.src, b.data};
  endfunction

  function automatic beat_t randBeat(bit eom);
    beat_t b;
    b.cmd     = $urandom();
    b.cmd[22] = eom;
    b.dst     = {$urandom(), $urandom()};
    b.src     = {$urandom(), $urandom()};
    b.data    = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
    return b;
  endfunction

  // Reference arbitration: -1 none, 0 response, 1 request.
  function automatic int pickSide(bit rv, bit qv);
    if (lockSide == 0) return rv ? 0 : -1;
    if (lockSide == 1) return qv ? 1 : -1;
    if (rv && qv) begin
`ifdef UMI_MERGER_RESP_PRIO_EN
      return 0;
`else
      return (lastSide == 0) ? 1 : 0;
`endif
    end
    if (rv) return 0;
    if (qv) return 1;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [415:0] act, input logic [415:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic addMsg(input int side, input int len);
    for (int i = 0; i < len; i++) begin
      if (side == 0) respQ.push_back(randBeat(i == len - 1));
      else reqQ.push_back(randBeat(i == len - 1));
    end
  endtask

  // One clock cycle: drive inputs, predict and check readys, retire the accepted beat.
  task automatic applyStimulus(input int readyPct, input int gapPct);
    int    g;
    bit    acc;
    beat_t b;
    if (!presResp && respQ.size() > 0 && $urandom_range(99) >= gapPct) presResp = 1'b1;
    if (!presReq && reqQ.size() > 0 && $urandom_range(99) >= gapPct) presReq = 1'b1;
    b = presResp ? respQ[0] : randBeat($urandom_range(1));
    umi_resp_in_valid   = presResp;
    umi_resp_in_cmd     = b.cmd;
    umi_resp_in_dstaddr = b.dst;
    umi_resp_in_srcaddr = b.src;
    umi_resp_in_data    = b.data;
    b = presReq ? reqQ[0] : randBeat($urandom_range(1));
    umi_req_in_valid   = presReq;
    umi_req_in_cmd     = b.cmd;
    umi_req_in_dstaddr = b.dst;
    umi_req_in_srcaddr = b.src;
    umi_req_in_data    = b.data;
    umi_out_ready = ($urandom_range(99) < readyPct);
    #1;
    g   = pickSide(presResp, presReq);
    acc = (g >= 0) && (expQ.size() == 0 || umi_out_ready);
    checkOutput("in_ready", {umi_resp_in_ready, umi_req_in_ready},
                {(acc && g == 0), (acc && g == 1)});
    @(posedge clk);
    if (acc) begin
      if (g == 0) begin
        b = respQ.pop_front();
        presResp = 1'b0;
      end else begin
        b = reqQ.pop_front();
        presReq = 1'b0;
      end
      expQ.push_back(b);
      lastSide = g;
      lockSide = b.cmd[22] ? -1 : g;
    end
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    umi_resp_in_valid = 1'b0;
    umi_req_in_valid  = 1'b0;
    umi_out_ready     = 1'b1;
    presResp = 1'b0;
    presReq  = 1'b0;
    respQ.delete();
    reqQ.delete();
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("ready_in_reset", {umi_resp_in_ready, umi_req_in_ready}, 2'b00);
      @(posedge clk);
      expQ.delete();
      lockSide = -1;
      lastSide = 1;
      #1;
    end
    rst = 1'b0;
    checkOutput("reset_out", {umi_out_valid, umi_out_cmd, umi_out_dstaddr, umi_out_data}, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (expQ.size() != 0 || respQ.size() != 0 || reqQ.size() != 0); i++)
      applyStimulus(100, 0);
  endtask

  // Monitor: the output must match the head of the expected queue every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        checkOutput("out_valid", umi_out_valid, expQ.size() != 0);
        if (umi_out_valid === 1'b1 && expQ.size() != 0) begin
          checkOutput("out_payload",
                      {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data},
                      packBeat(expQ[0]));
          if (umi_out_ready) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    beat_t b;
    rst = 1'b1;
    umi_out_ready = 1'b1;
    lockSide = -1;
    lastSide = 1;
    doReset();

    // Single source: four request beats, full throughput.
    for (int i = 1; i <= 4; i++) begin
      b = randBeat(1'b1);
      b.cmd  = 32'h0040_0001;
      b.data = 256'(i);
      reqQ.push_back(b);
    end
    for (int i = 0; i < 6; i++) applyStimulus(100, 0);

    // Contention with single-beat messages from both sides.
    doReset();
    for (int i = 0; i < 6; i++) begin
      addMsg(0, 1);
      addMsg(1, 1);
    end
    for (int i = 0; i < 14; i++) applyStimulus(100, 0);

    // Locking: request message grabs the port, responses wait.
    doReset();
    addMsg(1, 3);
    applyStimulus(100, 0);
    addMsg(0, 1);
    addMsg(0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(100, 0);

    // Backpressure mid-stream.
    doReset();
    for (int i = 0; i < 4; i++) begin
      addMsg(0, 1);
      addMsg(1, 1);
    end
    applyStimulus(100, 0);
    applyStimulus(100, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0);
    drain();

    // Reset in the middle of a locked request message.
    doReset();
    addMsg(1, 3);
    applyStimulus(100, 0);
    doReset();
    addMsg(0, 1);
    addMsg(1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(100, 0);

    // Randomized traffic with gaps and output stalls.
    doReset();
    for (int i = 0; i < 20; i++) begin
      addMsg(0, $urandom_range(1, 4));
      addMsg(1, $urandom_range(1, 4));
    end
    for (int i = 0; i < 400; i++) applyStimulus(70, 30);
    drain();
    applyStimulus(100, 0);
    applyStimulus(100, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
